// File: rtl/filter_ctrl.sv
// ============================================================================
// Module   : filter_ctrl
// Brief    : Decimation filter run controller: flush, settle, deliver, drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_ctrl #(
    parameter int DECIM     = 64,
    parameter int SETTLE    = 2,
    parameter int FLUSH_CYC = 4,
    parameter int W         = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic [7:0]   num_samples,
    output logic         filt_rst_n,
    input  logic [W-1:0] filt_data,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         busy,
    output logic         done,
    output logic         overflow
);

    localparam int c_PW          = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int c_FW          = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int c_SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int c_FLUSH_LAST  = (FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0;
    localparam int c_SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FLUSH  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [c_FW-1:0] r_flush_cnt;
    logic [c_SW-1:0] r_settle_cnt;
    logic [c_PW-1:0] r_phase;
    logic [7:0]      r_num;
    logic [7:0]      r_count;
    logic [W-1:0]    r_m_data;
    logic            r_m_valid;
    logic            r_overflow;
    logic            r_filt_rst_n;
    logic            r_done_pend;
    logic            r_done;

    logic w_active;
    logic w_tick;
    logic w_start_acc;
    logic w_load;
    logic w_drop;
    logic w_last;
    logic w_busy;

    assign w_active    = (r_state == S_SETTLE) || (r_state == S_RUN);
    assign w_tick      = w_active && (r_phase == c_PW'(DECIM - 1));
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_load      = (r_state == S_RUN) && w_tick && (!r_m_valid || m_ready);
    assign w_drop      = (r_state == S_RUN) && w_tick && r_m_valid && !m_ready;
    // num_samples == 0 selects continuous mode, so the terminal-count match is gated off.
    assign w_last      = w_load && (r_num != 8'd0) && ((r_count + 8'd1) == r_num);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; stop outranks every exit other than IDLE's start
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (stop)                                          w_next = S_DRAIN;
                else if (r_flush_cnt == c_FW'(c_FLUSH_LAST))       w_next = (SETTLE > 0) ? S_SETTLE : S_RUN;
            end
            S_SETTLE: begin
                if (stop)                                          w_next = S_DRAIN;
                else if (w_tick && r_settle_cnt == c_SW'(c_SETTLE_LAST)) w_next = S_RUN;
            end
            S_RUN: begin
                if (stop || w_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_m_valid || m_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_busy = 1'b1;
        if (r_state == S_IDLE) w_busy = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt  <= '0;
            r_settle_cnt <= '0;
            r_phase      <= '0;
        end else begin
            r_flush_cnt  <= (r_state == S_FLUSH) ? r_flush_cnt + c_FW'(1) : '0;
            if (r_state != S_SETTLE)  r_settle_cnt <= '0;
            else if (w_tick)          r_settle_cnt <= r_settle_cnt + c_SW'(1);
            if (!w_active)            r_phase <= '0;
            else if (w_tick)          r_phase <= '0;
            else                      r_phase <= r_phase + c_PW'(1);
        end
    end

    // Output slot, run bookkeeping and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_overflow   <= 1'b0;
            r_num        <= '0;
            r_count      <= '0;
            r_filt_rst_n <= 1'b0;
            r_done_pend  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (w_load) begin
                r_m_data  <= filt_data;
                r_m_valid <= 1'b1;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end

            if (w_start_acc)  r_overflow <= 1'b0;
            else if (w_drop)  r_overflow <= 1'b1;

            if (w_start_acc) r_num <= num_samples;

            // Saturating, so a continuous run can never alias a terminal count.
            if (w_start_acc)                      r_count <= '0;
            else if (w_load && r_count != 8'hFF)  r_count <= r_count + 8'd1;

            r_filt_rst_n <= (w_next == S_SETTLE) || (w_next == S_RUN);
            r_done_pend  <= (r_state == S_DRAIN) && (w_next == S_IDLE);
            r_done       <= r_done_pend;
        end
    end

    assign filt_rst_n = r_filt_rst_n;
    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;
    assign busy       = w_busy;
    assign done       = r_done;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_filter_ctrl.sv
// Randomized bench for filter_ctrl; expected outputs come from closed-form run timing.
`timescale 1ns/1ps
`default_nettype none

module tb_filter_ctrl;

    localparam int D  = 64;
    localparam int S  = 2;
    localparam int F  = 4;
    localparam int W  = 12;
    localparam int T0 = 1 + F;              // first SETTLE cycle after the start cycle

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [7:0]   num_samples = 8'd0;
    logic         filt_rst_n;
    logic [W-1:0] filt_data = '0;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic         busy;
    logic         done;
    logic         overflow;

    int vectors = 0;
    int errors  = 0;
    logic [W-1:0] fd [0:1023];

    filter_ctrl #(.DECIM(D), .SETTLE(S), .FLUSH_CYC(F), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .num_samples(num_samples), .filt_rst_n(filt_rst_n),
        .filt_data(filt_data), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic int vcyc(input int k);   // cycle in which sample k is first visible
        return T0 + (S + k) * D;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive_data(input int rel);
        fd[rel]   = W'($urandom);
        filt_data = fd[rel];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        vectors++;
        if ({filt_rst_n, busy, done, overflow, m_valid} !== 5'b0 || m_data !== '0) begin
            errors++;
            $display("FAIL reset_state got frn/busy/done/ovf/mv=%b m_data=%h exp 00000/0",
                     {filt_rst_n, busy, done, overflow, m_valid}, m_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_run(input int n, input logic with_stop);
        int e;
        logic [4:0] exp, got;
        e = vcyc(n);
        start = 1'b1; stop = with_stop; num_samples = 8'(n); m_ready = 1'b1;
        drive_data(0);
        for (int rel = 1; rel <= e + 4; rel++) begin
            step();
            exp[4] = (rel >= T0) && (rel <= e - 1);
            exp[3] = (rel >= 1) && (rel <= e);
            exp[2] = (rel == e + 2);
            exp[1] = 1'b0;
            exp[0] = 1'b0;
            for (int k = 1; k <= n; k++) if (rel == vcyc(k)) exp[0] = 1'b1;
            got = {filt_rst_n, busy, done, overflow, m_valid};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single_run n=%0d rel=%0d frn/busy/done/ovf/mv got=%b exp=%b", n, rel, got, exp);
            end
            if (exp[0]) begin
                vectors++;
                if (m_data !== fd[rel-1]) begin
                    errors++;
                    $display("FAIL single_run_data rel=%0d got=%h exp=%h", rel, m_data, fd[rel-1]);
                end
            end
            start = 1'b0; stop = 1'b0; num_samples = 8'($urandom);
            drive_data(rel);
        end
    endtask

    task automatic test_backpressure();
        int v1, rel_rdy, rel_stop, e;
        logic [4:0] exp, got;
        v1 = vcyc(1); rel_rdy = v1 + 150; rel_stop = rel_rdy + 3; e = rel_stop + 1;
        start = 1'b1; num_samples = 8'd0; m_ready = 1'b1;
        drive_data(0);
        for (int rel = 1; rel <= e + 4; rel++) begin
            step();
            exp[4] = (rel >= T0) && (rel <= rel_stop);
            exp[3] = (rel >= 1) && (rel <= e);
            exp[2] = (rel == e + 2);
            exp[1] = (rel >= v1 + D);
            exp[0] = (rel >= v1) && (rel <= rel_rdy);
            got = {filt_rst_n, busy, done, overflow, m_valid};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL backpressure rel=%0d frn/busy/done/ovf/mv got=%b exp=%b", rel, got, exp);
            end
            if (exp[0]) begin
                vectors++;
                if (m_data !== fd[v1-1]) begin
                    errors++;
                    $display("FAIL backpressure_hold rel=%0d got=%h exp=%h", rel, m_data, fd[v1-1]);
                end
            end
            start = 1'b0;
            m_ready = (rel < v1) || (rel >= rel_rdy);
            stop = (rel == rel_stop);
            drive_data(rel);
        end
        stop = 1'b0;
    endtask

    task automatic test_stop_settle();
        int ts;
        logic [4:0] exp, got;
        ts = T0 + 35;
        start = 1'b1; num_samples = 8'd3; m_ready = 1'b1;
        drive_data(0);
        for (int rel = 1; rel <= ts + 6; rel++) begin
            step();
            exp = {(rel >= T0) && (rel <= ts), (rel >= 1) && (rel <= ts + 1), rel == ts + 3, 1'b0, 1'b0};
            got = {filt_rst_n, busy, done, overflow, m_valid};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stop_settle rel=%0d frn/busy/done/ovf/mv got=%b exp=%b", rel, got, exp);
            end
            start = 1'b0;
            stop = (rel == ts);
            drive_data(rel);
        end
        stop = 1'b0;
    endtask

    task automatic test_stop_drain();
        int v1, ts, r;
        logic [4:0] exp, got;
        v1 = vcyc(1); ts = v1 + 3; r = ts + 1 + $urandom_range(3, 20);
        start = 1'b1; num_samples = 8'd0; m_ready = 1'b1;
        drive_data(0);
        for (int rel = 1; rel <= r + 4; rel++) begin
            step();
            exp = {(rel >= T0) && (rel <= ts), (rel >= 1) && (rel <= r), rel == r + 2,
                   1'b0, (rel >= v1) && (rel <= r)};
            got = {filt_rst_n, busy, done, overflow, m_valid};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stop_drain rel=%0d frn/busy/done/ovf/mv got=%b exp=%b", rel, got, exp);
            end
            if (exp[0]) begin
                vectors++;
                if (m_data !== fd[v1-1]) begin
                    errors++;
                    $display("FAIL stop_drain_data rel=%0d got=%h exp=%h", rel, m_data, fd[v1-1]);
                end
            end
            start = 1'b0;
            stop = (rel == ts);
            m_ready = (rel < v1) || (rel >= r);
            drive_data(rel);
        end
        stop = 1'b0;
    endtask

    task automatic test_back_to_back();
        int v1, v2, s1, s2, s3;
        logic [4:0] exp, got;
        logic [W-1:0] xd;
        v1 = vcyc(1); v2 = vcyc(2);
        s1 = $urandom_range(2, 60); s2 = $urandom_range(61, 180); s3 = $urandom_range(181, v2 - 6);
        start = 1'b1; num_samples = 8'd2; m_ready = 1'b1;
        drive_data(0);
        for (int rel = 1; rel <= v2 + 5; rel++) begin
            step();
            exp = {(rel >= T0) && (rel <= v2 - 1), (rel >= 1) && (rel <= v2), rel == v2 + 2,
                   1'b0, (rel >= v1) && (rel <= v2)};
            got = {filt_rst_n, busy, done, overflow, m_valid};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back rel=%0d frn/busy/done/ovf/mv got=%b exp=%b", rel, got, exp);
            end
            if (exp[0]) begin
                xd = (rel == v2) ? fd[v2-1] : fd[v1-1];
                vectors++;
                if (m_data !== xd) begin
                    errors++;
                    $display("FAIL back_to_back_data rel=%0d got=%h exp=%h", rel, m_data, xd);
                end
            end
            start = (rel == s1) || (rel == s2) || (rel == s3);
            num_samples = 8'($urandom);
            m_ready = (rel < v1) || (rel >= v2 - 1);
            drive_data(rel);
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset();
        int tr;
        tr = 230;
        start = 1'b1; num_samples = 8'd3; m_ready = 1'b1;
        drive_data(0);
        for (int rel = 1; rel <= tr; rel++) begin
            step();
            start = 1'b0;
            m_ready = (rel < vcyc(1));
            drive_data(rel);
        end
        vectors++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pending got mv=%b busy=%b exp 1/1", m_valid, busy);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({filt_rst_n, busy, done, overflow, m_valid} !== 5'b0 || m_data !== '0) begin
            errors++;
            $display("FAIL async_reset got frn/busy/done/ovf/mv=%b m_data=%h exp 00000/0",
                     {filt_rst_n, busy, done, overflow, m_valid}, m_data);
        end
        step();
        rst = 1'b0;
        m_ready = 1'b1;
        test_single_run(3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_run(3, 1'b0);
        test_single_run(int'($urandom_range(1, 4)), 1'b1);
        test_backpressure();
        test_single_run(1, 1'b0);
        test_stop_settle();
        test_stop_drain();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
